// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative RV64M multiplier (MUL/MULH/MULHSU/MULHU).
// It forms the 128-bit product one radix-2 shift-add step per cycle.
// Ports:
//   clk, rst_n (synchronous, active-low), flush
//   in_valid/in_ready, in_op, in_rs1, in_rs2, in_tag  : issue side
//   out_valid/out_ready, out_result, out_tag         : writeback side
//   busy                                             : not IDLE
// Optional build macro: MUL_EARLY_OUT_EN. When it is defined, the unit
// stops iterating once the remaining multiplier bits are all zero.
module mul_iter_unit #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]      op_q;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            neg;
    // 7 bits so the early-out alignment amount 64-cnt is representable
    logic [6:0]      cnt;

    logic            s1;
    logic            s2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;

    logic [XLEN-1:0] addend;
    logic [XLEN:0]   sum;

    logic              early;
    logic [2*XLEN-1:0] p_align;
    logic [2*XLEN-1:0] p_fix;

    // rs1 is signed for MULH and MULHSU, rs2 only for MULH
    assign s1   = (in_op == 2'b01) || (in_op == 2'b10);
    assign s2   = (in_op == 2'b01);
    assign abs1 = (s1 && in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
    assign abs2 = (s2 && in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;

    // one ripple add per cycle; carry-out becomes the new top bit
    assign addend = lo[0] ? mcand : '0;
    assign sum    = {1'b0, hi} + {1'b0, addend};

`ifdef MUL_EARLY_OUT_EN
    logic [XLEN-1:0] rem_mask;
    logic [6:0]      shamt;

    // bits of lo not yet consumed by the shift-add
    assign rem_mask = {XLEN{1'b1}} >> cnt;
    assign early    = ((lo & rem_mask) == '0);
    // after cnt steps the product sits in the top 64+cnt bits of P
    assign shamt    = 7'd64 - cnt;
    assign p_align  = {hi, lo} >> shamt;
`else
    assign early    = 1'b0;
    assign p_align  = {hi, lo};
`endif

    assign p_fix = neg ? -p_align : p_align;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (in_valid) state_nx = S_BUSY;
            S_BUSY: if (early || cnt == 7'd63) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            out_tag <= '0;
            mcand   <= '0;
            neg     <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && in_valid && !flush) begin
                op_q    <= in_op;
                out_tag <= in_tag;
                mcand   <= abs1;
                neg     <= (s1 & in_rs1[XLEN-1]) ^ (s2 & in_rs2[XLEN-1]);
                hi      <= '0;
                lo      <= abs2;
                cnt     <= '0;
            end else if (state == S_BUSY && !early) begin
                {hi, lo} <= {sum, lo[XLEN-1:1]};
                cnt      <= cnt + 7'd1;
            end else if (state == S_FIX) begin
                {hi, lo} <= p_fix;
            end
        end
    end

    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign out_result = (op_q == 2'b00) ? lo : hi;

endmodule

// File: tb/tb_mul_iter_unit.sv
// tb_mul_iter_unit: directed and random checks of mul_iter_unit
// against a 128-bit arithmetic reference model.
module tb_mul_iter_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [63:0] in_rs1;
    logic [63:0] in_rs2;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [5:0]  out_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_iter_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [1:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        logic [127:0] x, y, p;
        x = (op == 2'd1 || op == 2'd2) ? {{64{a[63]}}, a} : {64'd0, a};
        y = (op == 2'd1) ? {{64{b[63]}}, b} : {64'd0, b};
        p = x * y;
        return (op == 2'd0) ? p[63:0] : p[127:64];
    endfunction

    function automatic int ref_lat(input logic [1:0] op,
                                   input logic [63:0] b);
        logic [63:0] m;
        int          l;
        m = (op == 2'd1 && b[63]) ? -b : b;
        l = 2;
        for (int i = 0; i < 64; i++)
            if (m[i]) l = i + 3;
        if (l > 65) l = 65;
`ifdef MUL_EARLY_OUT_EN
        return l;
`else
        return (l > 0) ? 65 : 65;
`endif
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] tg,
                         input int hold);
        int          lat;
        logic [63:0] exp;
        exp = ref_res(op, a, b);
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op = op;
        in_rs1 = a;
        in_rs2 = b;
        in_tag = tg;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_rs1 = {$urandom, $urandom};
        in_rs2 = {$urandom, $urandom};
        in_tag = 6'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(ref_lat(op, b)));
        chk("result", out_result, exp);
        chk("tag", 64'(out_tag), 64'(tg));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", out_result, exp);
            chk("hold_tag", 64'(out_tag), 64'(tg));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic start_op(input logic [1:0] op, input logic [63:0] a,
                            input logic [63:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_op = op;
        in_rs1 = a;
        in_rs2 = b;
        in_tag = 6'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] corner [6];
        logic [63:0] a, b;
        int          seen;
        corner[0] = 64'h8000_0000_0000_0000;
        corner[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        corner[2] = 64'd0;
        corner[3] = 64'd1;
        corner[4] = 64'h7FFF_FFFF_FFFF_FFFF;
        corner[5] = 64'd3;

        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_op = 2'd0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_tag = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        do_op(2'd0, 64'd7, 64'd6, 6'd5, 0);
        do_op(2'd1, 64'h8000_0000_0000_0000,
              64'h8000_0000_0000_0000, 6'd1, 0);
        do_op(2'd0, 64'h8000_0000_0000_0000,
              64'h8000_0000_0000_0000, 6'd2, 0);
        do_op(2'd2, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 6'd3, 0);
        do_op(2'd3, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 6'd4, 10);
        do_op(2'd1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 6'd6, 0);

        for (int n = 0; n < 16; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(3) == 0) a = corner[$urandom_range(5)];
            if ($urandom_range(3) == 0) b = corner[$urandom_range(5)];
            if ($urandom_range(3) == 0) b = b >> $urandom_range(63);
            do_op(2'($urandom), a, b, 6'($urandom), $urandom_range(3));
        end

        start_op(2'd1, 64'd123, 64'hFFFF_0000_1234_5678);
        repeat (30) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        in_op = 2'd3;
        in_rs1 = 64'd11;
        in_rs2 = 64'd13;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        chk("flush_quiet", 64'(seen), 64'd0);
        do_op(2'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd9, 6'd33, 0);

        start_op(2'd0, 64'd77, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'd0, 64'd1000, 64'd1000, 6'd63, 1);

`ifdef MUL_EARLY_OUT_EN
        do_op(2'd3, 64'd3, 64'd1, 6'd7, 0);
        do_op(2'd0, 64'd3, 64'd1, 6'd8, 0);
        do_op(2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 6'd10, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
